// File: rtl/geig_pkg.sv
// Shared types and field widths for the multi-channel Geiger event counter.
package geig_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_SUM  = 2'd2
    } geig_state_e;

    localparam int          TS_W   = 24;
    localparam int          ID_W   = 8;
    localparam logic [7:0]  SUM_ID = 8'hFF;

endpackage

// File: rtl/geig_multi_counter_if.sv
// Valid/ready output bus carrying tagged count words, plus the overrun flag.
interface geig_multi_counter_if #(
    parameter int CNT_W = 16
);
    logic [CNT_W+31:0] G_DATA_STACK;
    logic              G_VALID;
    logic              G_READY;
    logic              G_OVERRUN;

    modport master (output G_DATA_STACK, output G_VALID, output G_OVERRUN, input G_READY);
    modport slave  (input G_DATA_STACK, input G_VALID, input G_OVERRUN, output G_READY);
endinterface

// File: rtl/geig_edge_detect.sv
// Per-channel input conditioning: 2-flop synchroniser, debounce shift register
// and a pulse on the edge where the shift register becomes {DEB_LO zeros, DEB_HI ones}.
module geig_edge_detect #(
    parameter int DEB_LO = 4,
    parameter int DEB_HI = 6
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic evt
);
    localparam int              SR_W    = DEB_LO + DEB_HI;
    localparam logic [SR_W-1:0] PATTERN = SR_W'((64'd1 << DEB_HI) - 64'd1);

    logic            sync1_q, sync2_q;
    logic [SR_W-1:0] sr_q, sr_d;

    // evt is combinational so the counter sees it on the same edge the pattern lands
    always_comb begin
        sr_d = {sr_q[SR_W-2:0], sync2_q};
        evt  = (sr_d == PATTERN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sr_q    <= '0;
        end else begin
            sync1_q <= din;
            sync2_q <= sync1_q;
            sr_q    <= sr_d;
        end
    end

endmodule

// File: rtl/geig_multi_counter.sv
// Multi-channel Geiger counter: windowed per-channel event counts, serialised as tagged words.
// Define GEIG_SUM_WORD_EN to append a saturated sum-of-all-channels word (ID 8'hFF) per window.
module geig_multi_counter
    import geig_pkg::*;
#(
    parameter int         N_CH         = 2,
    parameter int         CNT_W        = 16,
    parameter int         DEB_LO       = 4,
    parameter int         DEB_HI       = 6,
    parameter int         WINDOW_TICKS = 6000000,
    parameter logic [7:0] ID_BASE      = 8'h47
) (
    input  logic                   CLK_100KHZ,
    input  logic                   RESET,
    input  logic [TS_W-1:0]        TIMESTAMP,
    input  logic [N_CH-1:0]        GSTREAM,
    geig_multi_counter_if.master   gbus
);
    localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int TICK_W = (WINDOW_TICKS > 1) ? $clog2(WINDOW_TICKS) : 1;
    localparam int WORD_W = CNT_W + TS_W + ID_W;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic e);
        return (e && (c != {CNT_W{1'b1}})) ? c + CNT_W'(1) : c;
    endfunction

    function automatic logic [WORD_W-1:0] mk_word(input logic [CNT_W-1:0] c,
                                                  input logic [TS_W-1:0] ts,
                                                  input logic [ID_W-1:0] id);
        return {c, ts, id};
    endfunction

    logic [N_CH-1:0]   evt;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic [TS_W-1:0]   ts_q, ts_d;
    logic [CNT_W-1:0]  cnt_q [N_CH];
    logic [CNT_W-1:0]  cnt_d [N_CH];
    logic [CNT_W-1:0]  snap_q[N_CH];
    logic [CNT_W-1:0]  snap_d[N_CH];
    logic [CNT_W-1:0]  inc   [N_CH];
    logic              close_w, take_w;

    geig_state_e       state_q;
    logic [CH_W-1:0]   ch_q, ch_nxt;
    logic              valid_q, ovr_q;
    logic [WORD_W-1:0] data_q;

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        geig_edge_detect #(.DEB_LO(DEB_LO), .DEB_HI(DEB_HI)) u_edge (
            .clk (CLK_100KHZ),
            .rst (RESET),
            .din (GSTREAM[k]),
            .evt (evt[k])
        );
    end

    // Snapshots only load when the serializer is free; counters clear on every close regardless
    always_comb begin
        close_w = (tick_q == TICK_W'(WINDOW_TICKS - 1));
        take_w  = close_w && (state_q == ST_IDLE);
        tick_d  = close_w ? '0 : tick_q + TICK_W'(1);
        ts_d    = take_w ? TIMESTAMP : ts_q;
        ch_nxt  = ch_q + CH_W'(1);
        for (int k = 0; k < N_CH; k++) begin
            inc[k]    = sat_inc(cnt_q[k], evt[k]);
            cnt_d[k]  = close_w ? '0 : inc[k];
            snap_d[k] = take_w ? inc[k] : snap_q[k];
        end
    end

`ifdef GEIG_SUM_WORD_EN
    localparam int SUM_W = CNT_W + 4;
    logic [SUM_W-1:0] sum_wide;
    logic [CNT_W-1:0] sum_sat;

    always_comb begin
        sum_wide = '0;
        for (int k = 0; k < N_CH; k++) begin
            sum_wide = sum_wide + SUM_W'(snap_q[k]);
        end
        sum_sat = (sum_wide > SUM_W'({CNT_W{1'b1}})) ? {CNT_W{1'b1}} : sum_wide[CNT_W-1:0];
    end
`endif

    always_ff @(posedge CLK_100KHZ or posedge RESET) begin
        if (RESET) begin
            tick_q <= '0;
            ts_q   <= '0;
            for (int k = 0; k < N_CH; k++) begin
                cnt_q[k]  <= '0;
                snap_q[k] <= '0;
            end
        end else begin
            tick_q <= tick_d;
            ts_q   <= ts_d;
            for (int k = 0; k < N_CH; k++) begin
                cnt_q[k]  <= cnt_d[k];
                snap_q[k] <= snap_d[k];
            end
        end
    end

    // Serializer: first word is built from the snapshot being loaded on the same close edge
    always_ff @(posedge CLK_100KHZ or posedge RESET) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            ch_q    <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            ovr_q   <= 1'b0;
        end else begin
            ovr_q <= close_w && (state_q != ST_IDLE);
            case (state_q)
                ST_IDLE: begin
                    if (close_w) begin
                        state_q <= ST_SEND;
                        ch_q    <= '0;
                        valid_q <= 1'b1;
                        data_q  <= mk_word(snap_d[0], ts_d, ID_BASE);
                    end
                end
                ST_SEND: begin
                    if (gbus.G_READY) begin
                        if (ch_q == CH_W'(N_CH - 1)) begin
`ifdef GEIG_SUM_WORD_EN
                            state_q <= ST_SUM;
                            data_q  <= mk_word(sum_sat, ts_q, SUM_ID);
`else
                            state_q <= ST_IDLE;
                            valid_q <= 1'b0;
                            data_q  <= '0;
`endif
                        end else begin
                            ch_q   <= ch_nxt;
                            data_q <= mk_word(snap_q[ch_nxt], ts_q, ID_BASE + 8'(ch_nxt));
                        end
                    end
                end
`ifdef GEIG_SUM_WORD_EN
                ST_SUM: begin
                    if (gbus.G_READY) begin
                        state_q <= ST_IDLE;
                        valid_q <= 1'b0;
                        data_q  <= '0;
                    end
                end
`endif
                default: begin
                    state_q <= ST_IDLE;
                    valid_q <= 1'b0;
                    data_q  <= '0;
                end
            endcase
        end
    end

    assign gbus.G_VALID      = valid_q;
    assign gbus.G_DATA_STACK = data_q;
    assign gbus.G_OVERRUN    = ovr_q;

endmodule
